// File: rtl/diff_mon_pkg.sv
// Shared types and constants for the lockstep commit-stream monitor.
package diff_mon_pkg;

    typedef enum logic [1:0] {
        StRun,
        StPass,
        StFail
    } mon_state_e;

    typedef logic [2:0] fail_code_t;

    localparam fail_code_t FailNone       = 3'd0;
    localparam fail_code_t FailMismatch   = 3'd1;
    localparam fail_code_t FailTimeout    = 3'd2;
    localparam fail_code_t FailTohostDiff = 3'd3;
    localparam fail_code_t FailTohostFail = 3'd4;

    localparam int unsigned DefNch   = 2;
    localparam int unsigned DefDw    = 64;
    localparam int unsigned DefDepth = 8;
    localparam int unsigned DefCw    = 64;

    localparam int unsigned TohostW  = 64;

endpackage

// File: rtl/diff_mon_fifo.sv
// Per-channel commit buffer: synchronous FIFO, unregistered head output.
module diff_mon_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wptr_q, rptr_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A push into a full buffer is accepted only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since occupancy is tracked by pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/diff_sync_monitor.sv
// Lockstep commit-stream comparator with tohost verdict, timeout and dump window.
module diff_sync_monitor
    import diff_mon_pkg::*;
#(
    parameter int unsigned NCH   = DefNch,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned CW    = DefCw
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH-1:0]         commit_valid,
    output logic [NCH-1:0]         commit_ready,
    input  logic [NCH*DW-1:0]      commit_data,
    input  logic [NCH-1:0]         tohost_valid,
    input  logic [NCH*TohostW-1:0] tohost_data,
    input  logic [CW-1:0]          max_cycles,
    input  logic [CW-1:0]          dump_start,
    output logic                   dump_en,
    output logic                   done,
    output logic                   pass,
    output logic [2:0]             fail_code,
    output logic [1:0]             mismatch_ch,
    output logic [CW-1:0]          cycle_cnt
);

    mon_state_e         state_q, state_d;
    fail_code_t         fail_code_q, fail_code_d;
    logic [1:0]         mismatch_ch_q, mismatch_ch_d;
    logic [CW-1:0]      cycle_cnt_q, cycle_cnt_d;
    logic [NCH-1:0]     seen_q;
    logic [TohostW-1:0] tohost_q [NCH];

    logic [NCH-1:0]     fifo_full, fifo_empty, push;
    logic [DW-1:0]      head [NCH];
    logic               running, pop_all, mis_any, th_diff, th_one, all_seen, timeout;
    logic [1:0]         mis_idx;

    // Reset gates the handshake directly so nothing is accepted while it is held.
    assign running = (state_q == StRun) && !reset;
    assign push    = commit_valid & commit_ready;
    assign pop_all = running && (fifo_empty == '0);

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        diff_mon_fifo #(
            .DW   (DW),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clock(clock),
            .reset(reset),
            .push (push[g]),
            .wdata(commit_data[g*DW +: DW]),
            .pop  (pop_all),
            .rdata(head[g]),
            .full (fifo_full[g]),
            .empty(fifo_empty[g])
        );
    end

    // Compare heads against channel 0; descending scan leaves the lowest differing index.
    always_comb begin
        mis_any = 1'b0;
        mis_idx = 2'd0;
        for (int i = NCH - 1; i >= 1; i--) begin
            if (head[i] != head[0]) begin
                mis_any = 1'b1;
                mis_idx = 2'(i);
            end
        end
    end

    // Agreement and value of the latched tohost writes.
    always_comb begin
        th_diff = 1'b0;
        for (int i = 1; i < NCH; i++) begin
            if (tohost_q[i] != tohost_q[0]) th_diff = 1'b1;
        end
    end

    assign th_one   = (tohost_q[0] == TohostW'(1));
    assign all_seen = &seen_q;
    assign timeout  = (max_cycles != '0) && (cycle_cnt_q > max_cycles);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StRun;
            fail_code_q   <= FailNone;
            mismatch_ch_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            mismatch_ch_q <= mismatch_ch_d;
        end
    end

    // Next-state: terminating conditions checked in priority order.
    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        mismatch_ch_d = mismatch_ch_q;
        if (state_q == StRun) begin
            if (pop_all && mis_any) begin
                state_d       = StFail;
                fail_code_d   = FailMismatch;
                mismatch_ch_d = mis_idx;
            end else if (all_seen && th_diff) begin
                state_d     = StFail;
                fail_code_d = FailTohostDiff;
            end else if (all_seen && !th_one) begin
                state_d     = StFail;
                fail_code_d = FailTohostFail;
            end else if (timeout) begin
                state_d     = StFail;
                fail_code_d = FailTimeout;
            end else if (all_seen && (fifo_empty == '1)) begin
                state_d = StPass;
            end
        end
    end

    // Outputs decoded from state; verdict fields read zero outside FAIL.
    always_comb begin
        done         = (state_q != StRun);
        pass         = (state_q == StPass);
        fail_code    = (state_q == StFail) ? fail_code_q : FailNone;
        mismatch_ch  = (state_q == StFail) ? mismatch_ch_q : 2'd0;
        dump_en      = running && (cycle_cnt_q >= dump_start);
        commit_ready = running ? ~fifo_full : '0;
        cycle_cnt    = cycle_cnt_q;
    end

    // Cycle counter: counts only cycles that remain in RUN, so it freezes on the terminating one.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == StRun) && (state_d == StRun) && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) cycle_cnt_q <= '0;
        else       cycle_cnt_q <= cycle_cnt_d;
    end

    // First tohost write per channel is latched; later writes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            seen_q <= '0;
            for (int i = 0; i < NCH; i++) tohost_q[i] <= '0;
        end else if (state_q == StRun) begin
            for (int i = 0; i < NCH; i++) begin
                if (tohost_valid[i] && !seen_q[i]) begin
                    seen_q[i]   <= 1'b1;
                    tohost_q[i] <= tohost_data[i*TohostW +: TohostW];
                end
            end
        end
    end

endmodule

// File: doc/diff_sync_monitor.md
DIFF_SYNC_MONITOR -- requirements
Module: diff_sync_monitor

Interface
REQ-001 SHALL take parameter NCH, default 2, number of lockstep harness channels (DUT plus variants), legal 2..4.
REQ-002 SHALL take parameter DW, default 64, commit-record width in bits.
REQ-003 SHALL take parameter DEPTH, default 8, per-channel buffer entries, power of two, minimum 2.
REQ-004 SHALL take parameter CW, default 64, cycle-counter width in bits.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port commit_valid, input, NCH: per-channel retire strobe.
REQ-008 SHALL have port commit_ready, output, NCH: per-channel buffer not full.
REQ-009 SHALL have port commit_data, input, NCH*DW: per-channel retire record; channel i occupies bits [i*DW +: DW].
REQ-010 SHALL have port tohost_valid, input, NCH: per-channel tohost write strobe.
REQ-011 SHALL have port tohost_data, input, NCH*64: per-channel tohost value.
REQ-012 SHALL have port max_cycles, input, CW: timeout limit; 0 disables the timeout.
REQ-013 SHALL have port dump_start, input, CW: cycle at which wave dumping begins.
REQ-014 SHALL have port dump_en, output, 1: wave-dump window active.
REQ-015 SHALL have port done, output, 1: run terminated.
REQ-016 SHALL have port pass, output, 1: terminated successfully.
REQ-017 SHALL have port fail_code, output, 3: failure cause.
REQ-018 SHALL have port mismatch_ch, output, 2: lowest channel index that diverged.
REQ-019 SHALL have port cycle_cnt, output, CW: cycles spent in RUN.

Function
REQ-020 SHALL implement FSM states RUN, PASS and FAIL; reset enters RUN; PASS and FAIL are sticky until reset.
REQ-021 SHALL buffer each channel in its own FIFO; a write occurs when commit_valid and commit_ready are both high; commit_ready = !full.
REQ-022 SHALL, when every FIFO is non-empty in RUN, pop all heads in the same cycle and compare heads 1..NCH-1 against head 0.
REQ-023 SHALL, on any inequality, go to FAIL with fail_code=1 (MISMATCH) and mismatch_ch = lowest differing index, one cycle after the pop.
REQ-024 SHALL permit a simultaneous push and pop on a full FIFO; on that cycle commit_ready reflects full and stays low.
REQ-025 SHALL increment cycle_cnt every cycle in RUN, saturating at all-ones and frozen in PASS/FAIL.
REQ-026 SHALL, when max_cycles!=0 and cycle_cnt>max_cycles, go to FAIL with fail_code=2 (TIMEOUT).
REQ-027 SHALL, on the first tohost_valid per channel, latch tohost_data and a per-channel seen flag; later writes are ignored.
REQ-028 SHALL, once every seen flag is set, go to FAIL with fail_code=3 (TOHOST_DIFF) if the latched values differ.
REQ-029 SHALL, once every seen flag is set and the values agree, go to FAIL with fail_code=4 (TOHOST_FAIL) if value!=1.
REQ-030 SHALL, once every seen flag is set, the values agree, the value is 1 and all FIFOs are empty, go to PASS.
REQ-031 SHALL resolve simultaneous terminating conditions with priority MISMATCH > TOHOST_DIFF > TOHOST_FAIL > TIMEOUT > PASS.
REQ-032 SHALL assert dump_en in RUN when cycle_cnt>=dump_start (so dump_start=0 gives dump_en from the first RUN cycle), and deassert it in PASS/FAIL.
REQ-033 SHALL assert done in PASS/FAIL, pass only in PASS, and hold fail_code=0 and mismatch_ch=0 unless in FAIL.
REQ-034 SHALL drive commit_ready low in PASS/FAIL and discard further commits there.

Reset
REQ-035 SHALL, on reset, clear: FIFO pointers and occupancy, seen flags, latched tohost values, cycle_cnt=0, done=0, pass=0, fail_code=0, mismatch_ch=0, dump_en=0, commit_ready=0.
REQ-036 SHALL make commit_ready=all-ones the first cycle after reset deasserts.
REQ-037 SHALL let reset asserted mid-run (including in PASS/FAIL) abandon all state within one cycle.

Structure
REQ-038 SHALL place the state enum, fail-code constants (NONE=0, MISMATCH=1, TIMEOUT=2, TOHOST_DIFF=3, TOHOST_FAIL=4) and parameter defaults in package diff_mon_pkg.
REQ-039 SHALL instantiate NCH copies of sub-module diff_mon_fifo: DW wide, DEPTH deep, synchronous, with full/empty outputs and no output registering.

Verification
REQ-040 SHALL cover: NCH=2, identical streams 0x80000000..0x8000001C, both tohost=1 -> pass=1, fail_code=0.
REQ-041 SHALL cover: channel 1 record 3 = 0xDEAD, otherwise equal -> FAIL, fail_code=1, mismatch_ch=1.
REQ-042 SHALL cover: channel 0 runs 8 commits ahead with DEPTH=8 -> commit_ready[0]=0 until channel 1 commits, no loss, then pass.
REQ-043 SHALL cover: max_cycles=100 with no tohost -> FAIL, fail_code=2, cycle_cnt=101 frozen.
REQ-044 SHALL cover: tohost 1 vs 3 -> fail_code=3; both 5 -> fail_code=4; mismatch in the same cycle as timeout -> fail_code=1.
REQ-045 SHALL cover: dump_start=50 -> dump_en rises with cycle_cnt=50; reset at cycle 70 -> all outputs zero next cycle.
